// File: rtl/adc_mavg_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_mavg_filter_pkg
// Brief    : Shared constants and FSM state encoding for the ADC moving-average
//            filter and its ring-buffer sub-module.
// Revision : 1.0 - initial release
// ============================================================================
package adc_mavg_filter_pkg;

  // Default ADC sample width and log2 of the averaging window
  localparam int MAVG_DATA_W     = 10;
  localparam int MAVG_DEPTH_LOG2 = 4;

  // Sequencer states: wait for a sample, fold it into the sum, publish average
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPDATE  = 2'd1,
    ST_PUBLISH = 2'd2
  } mavg_state_e;

endpackage : adc_mavg_filter_pkg
`default_nettype wire

// File: rtl/mavg_ring.sv
`default_nettype none
// ============================================================================
// Module   : mavg_ring
// Brief    : 2^DEPTH_LOG2 x DATA_W sample window. One synchronous write port,
//            combinational read at the same address (the write pointer), and
//            a synchronous clear so unfilled slots read as zero.
// Revision : 1.0 - initial release
// ============================================================================
module mavg_ring
  import adc_mavg_filter_pkg::*;
#(
  parameter int DATA_W     = MAVG_DATA_W,
  parameter int DEPTH_LOG2 = MAVG_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear every slot on reset, otherwise write the new sample over the oldest
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // The slot about to be overwritten is the oldest sample in the window
  assign rdata_o = mem_q[addr_i];

endmodule : mavg_ring
`default_nettype wire

// File: rtl/adc_mavg_filter.sv
`default_nettype none
// ============================================================================
// Module   : adc_mavg_filter
// Brief    : Moving average over the last 2^DEPTH_LOG2 ADC conversions.
//            A rising edge of data_valid captures a sample; the running sum is
//            updated by adding the new sample and subtracting the one it
//            replaces, then sum >> DEPTH_LOG2 is published with a 1-cycle
//            avg_valid pulse. Edges arriving while busy are dropped and flagged.
// Revision : 1.0 - initial release
// ============================================================================
module adc_mavg_filter
  import adc_mavg_filter_pkg::*;
#(
  parameter int DATA_W     = MAVG_DATA_W,
  parameter int DEPTH_LOG2 = MAVG_DEPTH_LOG2
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              buf_full,
  output logic              overrun
);

  // Sum is wide enough to hold a full window of max-scale samples
  localparam int SUM_W = DATA_W + DEPTH_LOG2;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   FILL_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   FILL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

  mavg_state_e             state_q;
  logic                    dv_q;
  logic [DATA_W-1:0]       sample_q;
  logic [SUM_W-1:0]        sum_q;
  logic [SUM_W-1:0]        sum_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q;
  logic [DEPTH_LOG2:0]     fill_q;
  logic [DATA_W-1:0]       avg_q;
  logic                    avg_valid_q;
  logic                    buf_full_q;
  logic                    overrun_q;
  logic [DATA_W-1:0]       oldest;
  logic                    ring_we;
  logic                    sample_edge;

  assign sample_edge = data_valid & ~dv_q;
  assign ring_we     = (state_q == ST_UPDATE);

  // The subtracted term was itself added earlier, so the sum stays in range
  assign sum_d = sum_q + {{DEPTH_LOG2{1'b0}}, sample_q}
                       - {{DEPTH_LOG2{1'b0}}, oldest};

  mavg_ring #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ring (
    .clk     (sysclk),
    .rst     (rst),
    .we_i    (ring_we),
    .addr_i  (wr_ptr_q),
    .wdata_i (sample_q),
    .rdata_o (oldest)
  );

  // Capture -> update running sum -> publish average, with registered outputs
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      // Loading the live level means a data_valid already high is not an edge
      dv_q        <= data_valid;
      sample_q    <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      buf_full_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dv_q        <= data_valid;
      avg_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sample_edge) begin
            sample_q <= data_in;
            state_q  <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          sum_q    <= sum_d;
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
          if (fill_q != FILL_MAX) begin
            fill_q <= fill_q + FILL_ONE;
          end
          if (sample_edge) begin
            overrun_q <= 1'b1;
          end
          state_q <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          avg_q       <= sum_q[SUM_W-1:DEPTH_LOG2];
          avg_valid_q <= 1'b1;
          if (fill_q == FILL_MAX) begin
            buf_full_q <= 1'b1;
          end
          if (sample_edge) begin
            overrun_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = avg_valid_q;
  assign buf_full  = buf_full_q;
  assign overrun   = overrun_q;

endmodule : adc_mavg_filter
`default_nettype wire

// File: tb/tb_adc_mavg_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_mavg_filter
// Brief    : Self-checking bench for adc_mavg_filter. Expected averages are
//            queued as samples are driven and compared when avg_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_mavg_filter;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [9:0] data_in;
  logic       data_valid;
  logic [9:0] avg_out;
  logic       avg_valid;
  logic       buf_full;
  logic       overrun;

  adc_mavg_filter #(
    .DATA_W     (10),
    .DEPTH_LOG2 (4)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .buf_full   (buf_full),
    .overrun    (overrun)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [9:0] din;
    logic [9:0] exp_avg;
    logic       exp_full;
  } vec_t;

  typedef struct {
    logic [9:0] avg;
    logic       full;
  } exp_t;

  vec_t vecs [32];
  exp_t sb_q [$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Every avg_valid pulse must match the oldest queued expectation
  always @(negedge sysclk) begin
    if (rst === 1'b0 && avg_valid === 1'b1) begin
      pulses++;
      if (sb_q.size() == 0) begin
        check("unexpected_avg_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("avg_out", {22'd0, avg_out}, {22'd0, mon_e.avg});
        check("buf_full_at_pulse", {31'd0, buf_full}, {31'd0, mon_e.full});
      end
    end
  end

  task automatic do_reset();
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (3) @(posedge sysclk);
    #1 rst = 1'b0;
  endtask

  // One clean data_valid pulse, then enough idle cycles for the result
  task automatic send_sample(input logic [9:0] v, input exp_t e);
    @(posedge sysclk);
    #1;
    data_in    = v;
    data_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge sysclk);
    #1 data_valid = 1'b0;
    repeat (4) @(posedge sysclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int k;

    // Ramp up over an empty window, then drain back down to zero
    for (int i = 0; i < 16; i++) begin
      vecs[i].din      = 10'd640;
      vecs[i].exp_avg  = 10'(40 * (i + 1));
      vecs[i].exp_full = (i == 15);
    end
    for (int i = 16; i < 32; i++) begin
      vecs[i].din      = 10'd0;
      vecs[i].exp_avg  = 10'(640 - 40 * (i - 15));
      vecs[i].exp_full = 1'b1;
    end

    do_reset();
    @(negedge sysclk);
    check("reset_avg_out",   {22'd0, avg_out},   32'd0);
    check("reset_avg_valid", {31'd0, avg_valid}, 32'd0);
    check("reset_buf_full",  {31'd0, buf_full},  32'd0);
    check("reset_overrun",   {31'd0, overrun},   32'd0);

    for (int i = 0; i < 32; i++) begin
      send_sample(vecs[i].din, '{avg: vecs[i].exp_avg, full: vecs[i].exp_full});
    end
    check("window_drained_buf_full", {31'd0, buf_full}, 32'd1);

    // Level held high: one pulse, landing on the third edge after detection
    p0 = pulses;
    @(posedge sysclk);
    #1;
    data_in    = 10'd320;
    data_valid = 1'b1;
    sb_q.push_back('{avg: 10'd20, full: 1'b1});
    @(negedge sysclk);
    @(negedge sysclk);
    check("lat_edge1_valid", {31'd0, avg_valid}, 32'd0);
    @(negedge sysclk);
    check("lat_edge2_valid", {31'd0, avg_valid}, 32'd0);
    @(negedge sysclk);
    check("lat_edge3_valid", {31'd0, avg_valid}, 32'd1);
    @(negedge sysclk);
    check("lat_edge4_valid", {31'd0, avg_valid}, 32'd0);
    repeat (5000) @(posedge sysclk);
    #1 data_valid = 1'b0;
    repeat (3) @(posedge sysclk);
    check("held_level_pulses",  pulses - p0,        32'd1);
    check("held_level_overrun", {31'd0, overrun},   32'd0);

    // A second rise while busy is dropped and flagged
    p0 = pulses;
    @(posedge sysclk);
    #1;
    data_in    = 10'd160;
    data_valid = 1'b1;
    sb_q.push_back('{avg: 10'd30, full: 1'b1});
    @(posedge sysclk);
    #1 data_valid = 1'b0;
    @(posedge sysclk);
    #1;
    data_in    = 10'd999;
    data_valid = 1'b1;
    @(posedge sysclk);
    #1 data_valid = 1'b0;
    repeat (6) @(posedge sysclk);
    check("busy_edge_overrun", {31'd0, overrun}, 32'd1);
    check("busy_edge_pulses",  pulses - p0,      32'd1);

    // Window sum is now 480; a 520 sample brings it to 1000, reset hits PUBLISH
    p0 = pulses;
    @(posedge sysclk);
    #1;
    data_in    = 10'd520;
    data_valid = 1'b1;
    @(posedge sysclk);
    #1 data_valid = 1'b0;
    @(posedge sysclk);
    #1 rst = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    check("rst_publish_avg_out",   {22'd0, avg_out},   32'd0);
    check("rst_publish_avg_valid", {31'd0, avg_valid}, 32'd0);
    check("rst_publish_buf_full",  {31'd0, buf_full},  32'd0);
    check("rst_publish_overrun",   {31'd0, overrun},   32'd0);
    @(posedge sysclk);
    #1 rst = 1'b0;
    check("rst_publish_pulses", pulses - p0, 32'd0);
    send_sample(10'd160, '{avg: 10'd10, full: 1'b0});

    // data_valid high across reset release must not register as an edge
    rst        = 1'b1;
    data_valid = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 rst = 1'b0;
    p0 = pulses;
    repeat (8) @(posedge sysclk);
    check("dv_high_at_release_pulses", pulses - p0, 32'd0);
    #1 data_valid = 1'b0;

    // Full-scale samples past the wrap point
    for (int i = 0; i < 20; i++) begin
      k = (i < 16) ? (i + 1) : 16;
      send_sample(10'd1023, '{avg: 10'((k * 1023) / 16), full: (i >= 15)});
    end
    check("full_scale_avg_out", {22'd0, avg_out}, 32'd1023);

    repeat (10) @(posedge sysclk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_adc_mavg_filter
`default_nettype wire
